ctrl_pipe_regs: RTL
===================

// Module: ctrl_pipe_regs
// PURPOSE
//  Control/register-tag pipeline immediately downstream of the CPU controller.
//  Captures decoded control plus rs/rt/rd tags at ID/EX, then carries them through EX/MEM and MEM/WB.
//  Resolves the write-destination register in EX.
//  Returns IDExRs/IDExRt/IDExMemRead/ExMemRd/MemWBRd and the RegWrite flags to hazard + forwarding logic.
// PARAMETERS
//  REG_AW   5   register-address width
//  ALUOP_W  3   ALU opcode width
//  PERF_W   16  width of each perf counter (only used with CTRL_PIPE_PERF_EN)
// PORTS
//  clk            in   1        clock; all state updates on rising edge
//  rst            in   1        synchronous reset, active-low
//  memStall       in   1        1 = freeze all three stages this cycle
//  IDExFlush      in   1        1 = load bubble into ID/EX instead of ID-stage control
//  IDValid        in   1        ID stage holds a real instruction (0 after IFIDFlush)
//  ALUSrc         in   1        ID-stage control from controller
//  ALUOpc         in   ALUOP_W  ID-stage control from controller
//  RegDst         in   2        00=rt, 01=rd, 10=$31, 11=reserved
//  MemRead        in   1        ID-stage control
//  MemWrite       in   1        ID-stage control
//  RegWrite       in   1        ID-stage control
//  RegData        in   2        ID-stage write-back source select
//  IFIDRs         in   REG_AW   rs field of IF/ID instruction
//  IFIDRt         in   REG_AW   rt field of IF/ID instruction
//  IFIDRd         in   REG_AW   rd field of IF/ID instruction
//  exALUSrc       out  1        ID/EX ALUSrc
//  exALUOpc       out  ALUOP_W  ID/EX ALUOpc
//  IDExRs         out  REG_AW   ID/EX rs tag
//  IDExRt         out  REG_AW   ID/EX rt tag
//  IDExMemRead    out  1        ID/EX MemRead
//  ExMemRd        out  REG_AW   resolved destination, EX/MEM
//  ExMemRegWrite  out  1        EX/MEM RegWrite
//  ExMemMemRead   out  1        EX/MEM MemRead
//  ExMemMemWrite  out  1        EX/MEM MemWrite
//  ExMemRegData   out  2        EX/MEM RegData
//  MemWBRd        out  REG_AW   MEM/WB destination
//  MemWBRegWrite  out  1        MEM/WB RegWrite
//  MemWBRegData   out  2        MEM/WB RegData
//  MemWBValid     out  1        MEM/WB holds a real instruction (retire strobe)
// BEHAVIOUR
//  - Reset: rst==0 at posedge clears every stage register; all outputs 0, valid bits 0.
//  - Reset overrides memStall and IDExFlush.
//  - Stall: memStall==1 holds all stage registers unchanged; stall beats flush (IDExFlush ignored).
//  - Normal advance, 1 cycle per stage:
//    - ID/EX <= inputs.
//    - EX/MEM <= ID/EX plus resolved destination.
//    - MEM/WB <= EX/MEM.
//  - Flush: IDExFlush==1 (no stall) loads a bubble into ID/EX.
//    - Bubble: every control bit, tag and valid = 0.
//    - EX/MEM and MEM/WB still advance normally.
//  - IDValid==0 is also treated as a bubble into ID/EX.
//  - Destination resolved when moving ID/EX->EX/MEM:
//    - RegDst 00 -> rt; 01 -> rd; 10 -> 5'd31; 11 -> 0 with RegWrite forced 0.
//    - Resolved destination 0 forces ExMemRegWrite=0 (no forwarding from $0).
//  - Latency: ID-stage inputs appear on ID/EX outputs 1 cycle after capture, ExMem* 2, MemWB* 3 (absent stalls).
//  - Outputs are registered only; no combinational input->output path.
// CONFIGURATION
//  CTRL_PIPE_PERF_EN defined: adds outputs perfRetired [PERF_W] and perfBubbles [PERF_W].
//  - perfRetired: +1 each non-stalled cycle MemWBValid is loaded 1.
//  - perfBubbles: +1 each non-stalled cycle ID/EX is loaded with a bubble.
//  - Both saturate at all-ones; both cleared by reset.
//  CTRL_PIPE_PERF_EN undefined: no counters and no perf ports; all other behaviour identical.
// TESTING
//  1 Reset: hold rst=0 2 cycles with random inputs -> all outputs 0; rst=1 then resumes cleanly.
//  2 R-type RegDst=01, rd=5, RegWrite=1 -> ExMemRd=5, ExMemRegWrite=1 at +2; MemWBRd=5, MemWBValid=1 at +3.
//  3 Load-use: IDExFlush=1 for 1 cycle -> ID/EX zero next cycle; older EX/MEM still advances to MEM/WB.
//  4 memStall=1 for 3 cycles with IDExFlush=1 -> all outputs frozen, no bubble; release -> resumes in order.
//  5 jal RegDst=10 -> ExMemRd=31; RegDst=01 with rd=0, RegWrite=1 -> ExMemRegWrite=0.
//  6 PERF_EN with PERF_W=4: 20 retires -> perfRetired=15 (saturated); 2 flushes -> perfBubbles=2.

Source files
------------

// File: rtl/ctrl_pipe_regs_if.sv
// ctrl_pipe_regs_if: ID-stage control in, pipeline control/tag bundle out.
// Optional perf ports present when CTRL_PIPE_PERF_EN is defined.
//   master: drives ID-stage control, stall/flush; reads staged control/tags.
//   slave : the pipeline register block.
interface ctrl_pipe_regs_if #(
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 3
`ifdef CTRL_PIPE_PERF_EN
    , parameter int PERF_W = 16
`endif
);
    logic               memStall;
    logic               IDExFlush;
    logic               IDValid;
    logic               ALUSrc;
    logic [ALUOP_W-1:0] ALUOpc;
    logic [1:0]         RegDst;
    logic               MemRead;
    logic               MemWrite;
    logic               RegWrite;
    logic [1:0]         RegData;
    logic [REG_AW-1:0]  IFIDRs;
    logic [REG_AW-1:0]  IFIDRt;
    logic [REG_AW-1:0]  IFIDRd;

    logic               exALUSrc;
    logic [ALUOP_W-1:0] exALUOpc;
    logic [REG_AW-1:0]  IDExRs;
    logic [REG_AW-1:0]  IDExRt;
    logic               IDExMemRead;
    logic [REG_AW-1:0]  ExMemRd;
    logic               ExMemRegWrite;
    logic               ExMemMemRead;
    logic               ExMemMemWrite;
    logic [1:0]         ExMemRegData;
    logic [REG_AW-1:0]  MemWBRd;
    logic               MemWBRegWrite;
    logic [1:0]         MemWBRegData;
    logic               MemWBValid;
`ifdef CTRL_PIPE_PERF_EN
    logic [PERF_W-1:0]  perfRetired;
    logic [PERF_W-1:0]  perfBubbles;
`endif

    modport master (
        output memStall, IDExFlush, IDValid,
        output ALUSrc, ALUOpc, RegDst, MemRead, MemWrite,
        output RegWrite, RegData, IFIDRs, IFIDRt, IFIDRd,
        input  exALUSrc, exALUOpc, IDExRs, IDExRt, IDExMemRead,
        input  ExMemRd, ExMemRegWrite, ExMemMemRead,
        input  ExMemMemWrite, ExMemRegData,
        input  MemWBRd, MemWBRegWrite, MemWBRegData, MemWBValid
`ifdef CTRL_PIPE_PERF_EN
        , input perfRetired, perfBubbles
`endif
    );

    modport slave (
        input  memStall, IDExFlush, IDValid,
        input  ALUSrc, ALUOpc, RegDst, MemRead, MemWrite,
        input  RegWrite, RegData, IFIDRs, IFIDRt, IFIDRd,
        output exALUSrc, exALUOpc, IDExRs, IDExRt, IDExMemRead,
        output ExMemRd, ExMemRegWrite, ExMemMemRead,
        output ExMemMemWrite, ExMemRegData,
        output MemWBRd, MemWBRegWrite, MemWBRegData, MemWBValid
`ifdef CTRL_PIPE_PERF_EN
        , output perfRetired, perfBubbles
`endif
    );
endinterface

// File: rtl/ctrl_pipe_regs.sv
// ctrl_pipe_regs: ID/EX, EX/MEM, MEM/WB control + register-tag pipeline.
// Ports: clk, rst (sync, active-low), bus (ctrl_pipe_regs_if.slave).
// Define CTRL_PIPE_PERF_EN for saturating retire/bubble counters.
module ctrl_pipe_regs #(
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 3
`ifdef CTRL_PIPE_PERF_EN
    , parameter int PERF_W = 16
`endif
) (
    input logic clk,
    input logic rst,
    ctrl_pipe_regs_if.slave bus
);
    typedef struct packed {
        logic               valid;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_opc;
        logic [1:0]         reg_dst;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic [1:0]         reg_data;
        logic [REG_AW-1:0]  rs;
        logic [REG_AW-1:0]  rt;
        logic [REG_AW-1:0]  rd;
    } id_ex_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [1:0]        reg_data;
        logic [REG_AW-1:0] rd;
    } ex_mem_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [1:0]        reg_data;
        logic [REG_AW-1:0] rd;
    } mem_wb_t;

    id_ex_t  r_idex;
    ex_mem_t r_exmem;
    mem_wb_t r_memwb;

    logic              w_bubble;
    id_ex_t            w_id;
    logic [REG_AW-1:0] w_dst;
    logic              w_dst_ok;
    ex_mem_t           w_ex;

    assign w_bubble = bus.IDExFlush | ~bus.IDValid;

    always_comb begin
        w_id           = '0;
        w_id.valid     = 1'b1;
        w_id.alu_src   = bus.ALUSrc;
        w_id.alu_opc   = bus.ALUOpc;
        w_id.reg_dst   = bus.RegDst;
        w_id.mem_read  = bus.MemRead;
        w_id.mem_write = bus.MemWrite;
        w_id.reg_write = bus.RegWrite;
        w_id.reg_data  = bus.RegData;
        w_id.rs        = bus.IFIDRs;
        w_id.rt        = bus.IFIDRt;
        w_id.rd        = bus.IFIDRd;
    end

    // Destination select; the reserved code writes nothing.
    always_comb begin
        w_dst    = '0;
        w_dst_ok = 1'b0;
        unique case (r_idex.reg_dst)
            2'b00: begin w_dst = r_idex.rt; w_dst_ok = 1'b1; end
            2'b01: begin w_dst = r_idex.rd; w_dst_ok = 1'b1; end
            2'b10: begin w_dst = '1;        w_dst_ok = 1'b1; end
            2'b11: begin w_dst = '0;        w_dst_ok = 1'b0; end
            default: begin w_dst = '0;      w_dst_ok = 1'b0; end
        endcase
    end

    // $0 is never a forwarding source, so drop RegWrite for it.
    always_comb begin
        w_ex           = '0;
        w_ex.valid     = r_idex.valid;
        w_ex.reg_write = r_idex.reg_write & w_dst_ok & (|w_dst);
        w_ex.mem_read  = r_idex.mem_read;
        w_ex.mem_write = r_idex.mem_write;
        w_ex.reg_data  = r_idex.reg_data;
        w_ex.rd        = w_dst;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idex  <= '0;
            r_exmem <= '0;
            r_memwb <= '0;
        end else if (!bus.memStall) begin
            r_idex  <= w_bubble ? '0 : w_id;
            r_exmem <= w_ex;
            r_memwb <= '{valid:     r_exmem.valid,
                         reg_write: r_exmem.reg_write,
                         reg_data:  r_exmem.reg_data,
                         rd:        r_exmem.rd};
        end
    end

`ifdef CTRL_PIPE_PERF_EN
    logic [PERF_W-1:0] r_perf_ret;
    logic [PERF_W-1:0] r_perf_bub;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf_ret <= '0;
            r_perf_bub <= '0;
        end else if (!bus.memStall) begin
            if (r_exmem.valid && r_perf_ret != '1)
                r_perf_ret <= r_perf_ret + PERF_W'(1);
            if (w_bubble && r_perf_bub != '1)
                r_perf_bub <= r_perf_bub + PERF_W'(1);
        end
    end

    assign bus.perfRetired = r_perf_ret;
    assign bus.perfBubbles = r_perf_bub;
`endif

    assign bus.exALUSrc      = r_idex.alu_src;
    assign bus.exALUOpc      = r_idex.alu_opc;
    assign bus.IDExRs        = r_idex.rs;
    assign bus.IDExRt        = r_idex.rt;
    assign bus.IDExMemRead   = r_idex.mem_read;
    assign bus.ExMemRd       = r_exmem.rd;
    assign bus.ExMemRegWrite = r_exmem.reg_write;
    assign bus.ExMemMemRead  = r_exmem.mem_read;
    assign bus.ExMemMemWrite = r_exmem.mem_write;
    assign bus.ExMemRegData  = r_exmem.reg_data;
    assign bus.MemWBRd       = r_memwb.rd;
    assign bus.MemWBRegWrite = r_memwb.reg_write;
    assign bus.MemWBRegData  = r_memwb.reg_data;
    assign bus.MemWBValid    = r_memwb.valid;
endmodule
